hop_seq: RTL and testbench

- Upstream sequencer for the hop scan-chain shifter.
- Holds a software-written table of hop configuration words and steps through it at a programmable dwell rate.
- For each hop it presents one TX word and a one-cycle start pulse; the shifter takes this pulse as its restart and latches the word in that cycle.
- It then waits a fixed scan window plus the dwell time before issuing the next hop.

---
 rtl/hop_seq.sv | 136 +++++++++++++
 tb/tb_hop_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hop_seq.sv
// hop_seq: steps through a table of hop words, pulsing the
// shifter restart once per hop and dwelling between hops.
module hop_seq #(
  parameter int TX_BITS_WIDTH = 64,
  parameter int NUM_HOPS      = 16,
  parameter int HOP_IDX_WIDTH = 4,
  parameter int DWELL_WIDTH   = 32,
  parameter int SCAN_CYCLES   = 240
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_wr_en,
  input  logic [HOP_IDX_WIDTH-1:0] cfg_wr_addr,
  input  logic [TX_BITS_WIDTH-1:0] cfg_wr_data,
  input  logic [HOP_IDX_WIDTH-1:0] num_hops_m1,
  input  logic [DWELL_WIDTH-1:0]   dwell_cycles,
  input  logic                     run_en,
  output logic                     scan_start,
  output logic [TX_BITS_WIDTH-1:0] scan_data,
  output logic [HOP_IDX_WIDTH-1:0] hop_idx,
  output logic                     busy,
  output logic                     hop_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DWELL
  } state_t;

  localparam logic [DWELL_WIDTH-1:0] SCAN_LAST =
    DWELL_WIDTH'(SCAN_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic [TX_BITS_WIDTH-1:0] r_mem [NUM_HOPS];
  logic [TX_BITS_WIDTH-1:0] r_scan_data;
  logic                     r_scan_start;
  logic [HOP_IDX_WIDTH-1:0] r_hop_idx;
  logic [HOP_IDX_WIDTH-1:0] w_idx_nxt;
  logic [DWELL_WIDTH-1:0]   r_cnt;
  logic [DWELL_WIDTH-1:0]   r_dwell;
  logic                     w_advance;
  logic                     w_hop_done;
  logic                     w_timed;

  // table has no reset so software contents survive it
  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
      r_mem[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_advance  = 1'b0;
    w_hop_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run_en) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next = S_SCAN;
      end
      S_SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_next    = run_en ? S_DWELL : S_IDLE;
          w_advance = ~run_en;
        end
      end
      S_DWELL: begin
        if (r_cnt == r_dwell - 1'b1) begin
          w_hop_done = 1'b1;
          w_advance  = 1'b1;
          w_next     = run_en ? S_LOAD : S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_idx_nxt = (r_hop_idx == num_hops_m1) ?
                     '0 : r_hop_idx + 1'b1;

  assign w_timed = (r_state == S_SCAN) ||
                   (r_state == S_DWELL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hop_idx    <= '0;
      r_scan_start <= 1'b0;
      r_scan_data  <= '0;
      r_cnt        <= '0;
      r_dwell      <= '0;
    end else begin
      r_scan_start <= (r_state == S_LOAD);
      if (r_state == S_LOAD) begin
        r_scan_data <= r_mem[r_hop_idx];
      end
      // dwell is captured once, in the pulse cycle
      if (r_scan_start) begin
        r_dwell <= (dwell_cycles == '0) ?
                   DWELL_WIDTH'(1) : dwell_cycles;
      end
      if (w_timed && (w_next == r_state)) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_advance) begin
        r_hop_idx <= w_idx_nxt;
      end
    end
  end

  assign scan_start = r_scan_start;
  assign scan_data  = r_scan_data;
  assign hop_idx    = r_hop_idx;
  assign busy       = (r_state != S_IDLE);
  assign hop_done   = w_hop_done;

endmodule

// File: tb/tb_hop_seq.sv
// tb_hop_seq: directed stimulus with a hop-position model
// and per-cycle output comparison for hop_seq.
module tb_hop_seq;

  localparam int TXW = 64;
  localparam int NH  = 16;
  localparam int IW  = 4;
  localparam int DW  = 32;
  localparam int SC  = 240;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_wr_en;
  logic [IW-1:0]  cfg_wr_addr;
  logic [TXW-1:0] cfg_wr_data;
  logic [IW-1:0]  num_hops_m1;
  logic [DW-1:0]  dwell_cycles;
  logic           run_en;
  logic           scan_start;
  logic [TXW-1:0] scan_data;
  logic [IW-1:0]  hop_idx;
  logic           busy;
  logic           hop_done;

  hop_seq #(
    .TX_BITS_WIDTH(TXW),
    .NUM_HOPS(NH),
    .HOP_IDX_WIDTH(IW),
    .DWELL_WIDTH(DW),
    .SCAN_CYCLES(SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_wr_en(cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
    .num_hops_m1(num_hops_m1),
    .dwell_cycles(dwell_cycles),
    .run_en(run_en),
    .scan_start(scan_start),
    .scan_data(scan_data),
    .hop_idx(hop_idx),
    .busy(busy),
    .hop_done(hop_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model: position within a hop, 0 = table-read cycle,
  // 1..SC = scan window, SC+1..SC+dwell = dwell
  logic [TXW-1:0] m_tab [NH];
  bit             m_busy = 1'b0;
  int             m_t = 0;
  int             m_dwell = 1;
  logic [IW-1:0]  m_idx = '0;
  logic [TXW-1:0] m_data = '0;

  int             p_cyc[$];
  logic [TXW-1:0] p_data[$];
  logic [IW-1:0]  p_idx[$];
  int             d_cyc[$];

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] i, input logic [IW-1:0] last);
    return (i == last) ? '0 : IW'(i + 1);
  endfunction

  task automatic chk(input string name,
                     input logic [TXW-1:0] act,
                     input logic [TXW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               name, cyc, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NH; i++) m_tab[i] = '0;
  end

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 1'b0;
      m_t    = 0;
      m_idx  = '0;
      m_data = '0;
    end else if (!m_busy) begin
      if (run_en) begin
        m_busy = 1'b1;
        m_t    = 0;
      end
    end else if (m_t == 0) begin
      m_data = m_tab[m_idx];
      m_t    = 1;
    end else if (m_t < SC) begin
      if (m_t == 1)
        m_dwell = (dwell_cycles == 0) ? 1 : int'(dwell_cycles);
      m_t++;
    end else if (m_t == SC && !run_en) begin
      m_busy = 1'b0;
      m_idx  = nxt(m_idx, num_hops_m1);
    end else if (m_t == SC + m_dwell) begin
      m_idx = nxt(m_idx, num_hops_m1);
      if (run_en) m_t = 0;
      else m_busy = 1'b0;
    end else begin
      m_t++;
    end
    if (cfg_wr_en) m_tab[cfg_wr_addr] = cfg_wr_data;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", TXW'(busy), TXW'(m_busy));
      chk("scan_start", TXW'(scan_start),
          TXW'(m_busy && m_t == 1));
      chk("hop_done", TXW'(hop_done),
          TXW'(m_busy && m_t > SC && m_t == SC + m_dwell));
      chk("hop_idx", TXW'(hop_idx), TXW'(m_idx));
      chk("scan_data", scan_data, m_data);
      if (scan_start) begin
        p_cyc.push_back(cyc);
        p_data.push_back(scan_data);
        p_idx.push_back(hop_idx);
      end
      if (hop_done) d_cyc.push_back(cyc);
    end
  end

  task automatic wr(input int a, input logic [TXW-1:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = IW'(a);
    cfg_wr_data = d;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (p_cyc.size() < n && k < 20000) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (p_cyc.size() < n) begin
      checks++;
      errors++;
      $display("FAIL pulse_timeout want=%0d got=%0d",
               n, p_cyc.size());
    end
  endtask

  logic [IW-1:0] exp_w [13];
  int n_busy;
  int n_done;

  initial begin
    exp_w = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13,
              4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd0};
    reset        = 1'b1;
    run_en       = 1'b0;
    cfg_wr_en    = 1'b0;
    cfg_wr_addr  = '0;
    cfg_wr_data  = '0;
    num_hops_m1  = 4'd3;
    dwell_cycles = 32'd10;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", TXW'(busy), '0);
    chk("rst_idx", TXW'(hop_idx), '0);
    chk("rst_data", scan_data, '0);
    chk("rst_start", TXW'(scan_start), '0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NH; i++) wr(i, 64'hA0 + TXW'(i));
    reset = 1'b0;

    // basic hop sequence
    run_en = 1'b1;
    wait_pulses(5);
    if (p_cyc.size() >= 5) begin
      chk("basic_d0", p_data[0], 64'hA0);
      chk("basic_d1", p_data[1], 64'hA1);
      chk("basic_d2", p_data[2], 64'hA2);
      chk("basic_d3", p_data[3], 64'hA3);
      chk("basic_d4", p_data[4], 64'hA0);
      chk("basic_gap", TXW'(p_cyc[1] - p_cyc[0]), 64'd251);
      chk("basic_gap4", TXW'(p_cyc[4] - p_cyc[3]), 64'd251);
    end
    if (d_cyc.size() >= 1 && p_cyc.size() >= 1)
      chk("done_ofs", TXW'(d_cyc[0] - p_cyc[0]), 64'd249);

    // zero dwell
    dwell_cycles = 32'd0;
    wait_pulses(7);
    if (p_cyc.size() >= 7) begin
      chk("zd_gap_old", TXW'(p_cyc[5] - p_cyc[4]), 64'd251);
      chk("zd_gap", TXW'(p_cyc[6] - p_cyc[5]), 64'd242);
    end

    // stop mid-scan on entry 3
    wait_pulses(8);
    if (p_cyc.size() >= 8) chk("stop_d", p_data[7], 64'hA3);
    repeat (4) @(posedge clk);
    #1;
    run_en = 1'b0;
    n_done = d_cyc.size();
    n_busy = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy) break;
      n_busy++;
    end
    chk("stop_busy_len", TXW'(n_busy), 64'd235);
    chk("stop_idx", TXW'(hop_idx), 64'd0);
    chk("stop_nodone", TXW'(d_cyc.size() - n_done), 64'd0);
    @(posedge clk);
    #1;
    dwell_cycles = 32'd10;
    run_en = 1'b1;
    wait_pulses(9);
    if (p_cyc.size() >= 9) chk("resume_d", p_data[8], 64'hA0);

    // rewrite active entry 0 during its scan
    wr(0, 64'hB0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rw_hold", scan_data, 64'hA0);
    @(posedge clk);
    #1;
    wait_pulses(13);
    if (p_cyc.size() >= 13) begin
      chk("rw_d9", p_data[9], 64'hA1);
      chk("rw_new", p_data[12], 64'hB0);
    end

    // reset in the dwell of that hop
    repeat (244) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rd_idx", TXW'(hop_idx), '0);
    chk("rd_data", scan_data, '0);
    chk("rd_busy", TXW'(busy), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    num_hops_m1 = 4'd15;
    wait_pulses(14);
    if (p_cyc.size() >= 14) begin
      chk("rd_restart_d", p_data[13], 64'hB0);
      chk("rd_restart_i", TXW'(p_idx[13]), 64'd0);
    end

    // lower the count while at index 6
    wait_pulses(20);
    if (p_cyc.size() >= 20) chk("wrap_at6", TXW'(p_idx[19]), 64'd6);
    num_hops_m1 = 4'd2;
    wait_pulses(33);
    if (p_cyc.size() >= 33) begin
      for (int i = 0; i < 13; i++)
        chk($sformatf("wrap_i%0d", i),
            TXW'(p_idx[20 + i]), TXW'(exp_w[i]));
    end

    run_en = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
